// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a proven-stable lock,
// then releases the system reset; recovers from timeout, lock loss and soft reset.
module pll_reset_sequencer #(
    parameter int PLL_RESET_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       soft_reset_req,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       ready,
    output logic [7:0] retry_count,
    output logic [7:0] lock_loss_count
);

    localparam int MAX_RS  = (PLL_RESET_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RESET_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_CYC = (MAX_RS > LOCK_TIMEOUT_CYCLES) ? MAX_RS : LOCK_TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_PLL_RESET = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABILIZE = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       retry_q, retry_d;
    logic [7:0]       loss_q, loss_d;
    logic             sync1_q, sync2_q;
    logic             locked_s;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_reset_q, sys_reset_d;
    logic             ready_q, ready_d;

    assign locked_s = sync2_q;

    // Two-flop synchronizer for the asynchronous lock indication
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pll_locked;
            sync2_q <= sync1_q;
        end
    end

    // State, counter, event counts and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_PLL_RESET;
            cnt_q       <= '0;
            retry_q     <= 8'd0;
            loss_q      <= 8'd0;
            pll_rst_q   <= 1'b1;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            pll_rst_q   <= pll_rst_d;
            sys_reset_q <= sys_reset_d;
            ready_q     <= ready_d;
        end
    end

    // Next-state, counter and event-count logic; soft reset overrides all
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_ONE;
        retry_d = retry_q;
        loss_d  = loss_q;
        if (soft_reset_req) begin
            state_d = ST_PLL_RESET;
        end else begin
            case (state_q)
                ST_PLL_RESET: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                    end else begin
                        state_d = ST_PLL_RESET;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = ST_STABILIZE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d = ST_PLL_RESET;
                        retry_d = sat_inc(retry_q);
                    end else begin
                        state_d = ST_WAIT_LOCK;
                    end
                end
                ST_STABILIZE: begin
                    if (!locked_s) begin
                        state_d = ST_WAIT_LOCK;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_STABILIZE;
                    end
                end
                ST_RUN: begin
                    cnt_d = cnt_q;
                    if (!locked_s) begin
                        state_d = ST_WAIT_LOCK;
                        loss_d  = sat_inc(loss_q);
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_PLL_RESET;
                end
            endcase
        end
        // A re-entry into PLL_RESET via soft reset must also restart the count
        if (soft_reset_req || (state_d != state_q)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_d;
        end
    end

    // Outputs decoded from the next state so they register alongside it
    always_comb begin
        pll_rst_d   = 1'b0;
        sys_reset_d = 1'b1;
        ready_d     = 1'b0;
        case (state_d)
            ST_PLL_RESET: pll_rst_d = 1'b1;
            ST_WAIT_LOCK: pll_rst_d = 1'b0;
            ST_STABILIZE: pll_rst_d = 1'b0;
            ST_RUN: begin
                sys_reset_d = 1'b0;
                ready_d     = 1'b1;
            end
            default: begin
                pll_rst_d   = 1'b1;
                sys_reset_d = 1'b1;
                ready_d     = 1'b0;
            end
        endcase
    end

    assign pll_rst         = pll_rst_q;
    assign sys_reset       = sys_reset_q;
    assign ready           = ready_q;
    assign retry_count     = retry_q;
    assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with a per-cycle reference model
// built from phase durations and a history of sampled lock values.
module tb_pll_reset_sequencer;

    localparam int PRC = 4;
    localparam int LSC = 8;
    localparam int LTC = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       soft_reset_req;
    logic       pll_rst;
    logic       sys_reset;
    logic       ready;
    logic [7:0] retry_count;
    logic [7:0] lock_loss_count;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    pll_reset_sequencer #(
        .PLL_RESET_CYCLES   (PRC),
        .LOCK_STABLE_CYCLES (LSC),
        .LOCK_TIMEOUT_CYCLES(LTC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pll_locked     (pll_locked),
        .soft_reset_req (soft_reset_req),
        .pll_rst        (pll_rst),
        .sys_reset      (sys_reset),
        .ready          (ready),
        .retry_count    (retry_count),
        .lock_loss_count(lock_loss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 reset, 1 waiting, 2 stabilizing, 3 running
    int m_phase   = 0;
    int m_elapsed = 0;
    int m_retry   = 0;
    int m_loss    = 0;
    bit m_hist[$] = '{1'b0, 1'b0};

    always @(posedge clk or negedge rst_n) begin
        bit ls;
        if (!rst_n) begin
            m_phase   = 0;
            m_elapsed = 0;
            m_retry   = 0;
            m_loss    = 0;
            m_hist    = '{1'b0, 1'b0};
        end else begin
            ls = m_hist.pop_front();
            m_hist.push_back(pll_locked);
            if (soft_reset_req) begin
                m_phase   = 0;
                m_elapsed = 0;
            end else begin
                m_elapsed++;
                if (m_phase == 0 && m_elapsed == PRC) begin
                    m_phase = 1; m_elapsed = 0;
                end else if (m_phase == 1 && ls) begin
                    m_phase = 2; m_elapsed = 0;
                end else if (m_phase == 1 && m_elapsed == LTC) begin
                    m_phase = 0; m_elapsed = 0;
                    if (m_retry < 255) m_retry++;
                end else if (m_phase == 2 && !ls) begin
                    m_phase = 1; m_elapsed = 0;
                end else if (m_phase == 2 && m_elapsed == LSC) begin
                    m_phase = 3; m_elapsed = 0;
                end else if (m_phase == 3 && !ls) begin
                    m_phase = 1; m_elapsed = 0;
                    if (m_loss < 255) m_loss++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_pll_rst",   int'(pll_rst),         (m_phase == 0) ? 1 : 0);
            chk("model_sys_reset", int'(sys_reset),       (m_phase != 3) ? 1 : 0);
            chk("model_ready",     int'(ready),           (m_phase == 3) ? 1 : 0);
            chk("model_retry",     int'(retry_count),     m_retry);
            chk("model_loss",      int'(lock_loss_count), m_loss);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        rst_n          = 1'b1;
        pll_locked     = 1'b0;
        soft_reset_req = 1'b0;
        #1 rst_n = 1'b0;
        cmp_en = 1'b1;
        step(3);
        chk("reset_pll_rst",   int'(pll_rst), 1);
        chk("reset_sys_reset", int'(sys_reset), 1);
        chk("reset_ready",     int'(ready), 0);
        chk("reset_retry",     int'(retry_count), 0);
        chk("reset_loss",      int'(lock_loss_count), 0);

        // Clean bring-up
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step(1);
            chk("bringup_pll_rst", int'(pll_rst), (k < 4) ? 1 : 0);
        end
        step(6);
        pll_locked = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            step(1);
            chk("bringup_sys_reset", int'(sys_reset), (k < 11) ? 1 : 0);
        end
        chk("bringup_ready", int'(ready), 1);
        chk("bringup_retry", int'(retry_count), 0);
        chk("bringup_loss",  int'(lock_loss_count), 0);

        // Lock loss in RUN, then relock resumes from STABILIZE
        step(3);
        pll_locked = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step(1);
            chk("loss_sys_reset", int'(sys_reset), (k == 3) ? 1 : 0);
            chk("loss_ready",     int'(ready), (k == 3) ? 0 : 1);
        end
        chk("loss_count", int'(lock_loss_count), 1);
        pll_locked = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            step(1);
            chk("relock_pll_rst",   int'(pll_rst), 0);
            chk("relock_sys_reset", int'(sys_reset), (k < 11) ? 1 : 0);
        end

        // Glitch midway through STABILIZE
        step(2);
        pll_locked = 1'b0;
        step(3);
        pll_locked = 1'b1;
        step(6);
        chk("glitch_mid_stab", int'(sys_reset), 1);
        pll_locked = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step(1);
            chk("glitch_sys_reset", int'(sys_reset), 1);
        end
        pll_locked = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            step(1);
            chk("glitch_release", int'(sys_reset), (k < 11) ? 1 : 0);
        end
        chk("glitch_loss", int'(lock_loss_count), 2);

        // Soft reset on the same edge a lock loss is seen
        step(2);
        pll_locked = 1'b0;
        step(2);
        chk("soft_pre_sys_reset", int'(sys_reset), 0);
        soft_reset_req = 1'b1;
        step(1);
        soft_reset_req = 1'b0;
        chk("soft_pll_rst", int'(pll_rst), 1);
        chk("soft_ready",   int'(ready), 0);
        chk("soft_loss",    int'(lock_loss_count), 2);
        for (int k = 1; k <= 4; k++) begin
            step(1);
            chk("soft_pll_rst_hold", int'(pll_rst), (k < 4) ? 1 : 0);
        end

        // Lock timeouts with lock held low
        for (int r = 1; r <= 3; r++) begin
            step(31);
            chk("timeout_wait_pll_rst", int'(pll_rst), 0);
            chk("timeout_wait_retry",   int'(retry_count), r - 1);
            step(1);
            chk("timeout_pll_rst", int'(pll_rst), 1);
            chk("timeout_retry",   int'(retry_count), r);
            step(4);
            chk("timeout_pll_rst_end", int'(pll_rst), 0);
        end
        step(36 * 300);
        chk("timeout_saturate", int'(retry_count), 255);

        // Async reset mid-STABILIZE
        soft_reset_req = 1'b1;
        pll_locked     = 1'b1;
        step(1);
        soft_reset_req = 1'b0;
        step(9);
        chk("stab_pll_rst",   int'(pll_rst), 0);
        chk("stab_sys_reset", int'(sys_reset), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_pll_rst",   int'(pll_rst), 1);
        chk("async_sys_reset", int'(sys_reset), 1);
        chk("async_ready",     int'(ready), 0);
        chk("async_retry",     int'(retry_count), 0);
        chk("async_loss",      int'(lock_loss_count), 0);
        step(1);
        rst_n = 1'b1;
        step(20);
        chk("rebringup_ready", int'(ready), 1);
        chk("rebringup_retry", int'(retry_count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
